cv32e40p_x_resp: RTL and testbench

Accelerator-side responder for the cv32e40p x-interface. It accepts or rejects offloaded instructions, buffers accepted ones in an in-order queue, and executes them one at a time. Compute instructions run on a fixed-latency ALU stub. Memory instructions are sent back to the core through the xmem request and response channels. Register results return on the result channel. The block sits opposite the core's offload dispatcher and serves as both reference coprocessor and verification partner.

---
 rtl/cv32e40p_x_resp.sv | 186 ++++++++++++++++++
 tb/tb_cv32e40p_x_resp.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_x_resp.sv
// cv32e40p_x_resp: accelerator-side x-interface responder. It accepts or rejects offloaded
// instructions and queues accepted ones in order. Compute ops run on a fixed-latency ALU stub.
// Loads and stores go out as single-beat xmem transactions.
module cv32e40p_x_resp #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned EXE_LAT     = 3,
  parameter logic [6:0]  COMP_OPCODE = 7'b0001011,
  parameter logic [6:0]  MEM_OPCODE  = 7'b0101011
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             x_valid_i,
  output logic             x_ready_o,
  output logic             x_accept_o,
  output logic             x_is_mem_op_o,
  input  logic [31:0]      x_instr_i,
  input  logic [2:0][31:0] x_rs_i,
  input  logic [2:0]       x_rs_valid_i,
  input  logic             x_rd_clean_i,
  output logic             x_rvalid_o,
  input  logic             x_rready_i,
  output logic [4:0]       x_rwaddr_o,
  output logic [31:0]      x_rdata_o,
  output logic             xmem_valid_o,
  input  logic             xmem_ready_i,
  output logic             xmem_req_type_o,  // 0 = READ, 1 = WRITE
  output logic [31:0]      xmem_addr_o,
  output logic [31:0]      xmem_wdata_o,
  output logic             xmem_endoftransaction_o,
  input  logic             xmem_rvalid_i,
  output logic             xmem_rready_o,
  input  logic [31:0]      xmem_rdata_i,
  input  logic             xmem_status_i
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned LatW = (EXE_LAT > 1) ? $clog2(EXE_LAT) : 1;

  typedef enum logic [2:0] {StIdle, StExec, StMreq, StMwait, StRes} state_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        is_mem;
    logic        wb;
    logic [31:0] a;
    logic [31:0] b;
  } entry_t;

  state_e          r_state, w_state_nxt;
  entry_t          r_mem [DEPTH];
  entry_t          r_cur, w_head, w_new;
  logic [PtrW-1:0] r_wptr, r_rptr;
  logic [CntW-1:0] r_cnt;
  logic [LatW-1:0] r_exe_cnt;
  logic [31:0]     r_res_data, w_alu;

  logic [6:0] w_opc;
  logic [4:0] w_rd;
  logic [2:0] w_f3;
  logic       w_is_comp, w_is_mem, w_is_load, w_known, w_wb;
  logic       w_ops_ok, w_full, w_can_accept, w_push, w_pop;
  logic       w_unused;

  assign w_opc     = x_instr_i[6:0];
  assign w_rd      = x_instr_i[11:7];
  assign w_f3      = x_instr_i[14:12];
  assign w_is_comp = (w_opc == COMP_OPCODE);
  assign w_is_mem  = (w_opc == MEM_OPCODE);
  assign w_known   = w_is_comp | w_is_mem;
  assign w_is_load = w_is_mem & ~w_f3[2];
  assign w_wb      = (w_is_comp | w_is_load) & (w_rd != 5'd0);
  assign w_ops_ok  = w_is_load ? x_rs_valid_i[0] : (x_rs_valid_i[0] & x_rs_valid_i[1]);
  // Fullness uses the registered count, so a same-cycle pop never frees a slot early.
  assign w_full       = (r_cnt == CntW'(DEPTH));
  assign w_can_accept = ~w_full & w_ops_ok & (x_rd_clean_i | ~w_wb);

  // Unknown opcodes always complete the handshake as a reject.
  assign x_ready_o     = x_valid_i & ~rst_i & (~w_known | w_can_accept);
  assign x_accept_o    = x_ready_o & w_known;
  assign x_is_mem_op_o = x_ready_o & w_is_mem;

  assign w_push = x_accept_o;
  assign w_pop  = (r_state == StIdle) & (r_cnt != '0);
  assign w_head = r_mem[r_rptr];
  assign w_new  = '{rd: w_rd, f3: w_f3, is_mem: w_is_mem, wb: w_wb, a: x_rs_i[0], b: x_rs_i[1]};

  assign w_unused = ^{x_instr_i[31:15], x_rs_i[2], x_rs_valid_i[2], r_cur.is_mem};

  // Queue payload storage; validity is tracked by the pointers, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= w_new;
  end

  // Queue pointers and occupancy count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      r_cnt <= r_cnt + CntW'(w_push) - CntW'(w_pop);
    end
  end

  // ALU stub for compute instructions.
  always_comb begin
    w_alu = r_cur.a;
    case (r_cur.f3)
      3'b000:  w_alu = r_cur.a + r_cur.b;
      3'b001:  w_alu = r_cur.a - r_cur.b;
      3'b010:  w_alu = r_cur.a ^ r_cur.b;
      3'b011:  w_alu = r_cur.a << r_cur.b[4:0];
      default: w_alu = r_cur.a;
    endcase
  end

  // Execution FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  // Execution FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_pop) w_state_nxt = w_head.is_mem ? StMreq : StExec;
      StExec:  if (r_exe_cnt == '0) w_state_nxt = r_cur.wb ? StRes : StIdle;
      StMreq:  if (xmem_ready_i) w_state_nxt = StMwait;
      StMwait: if (xmem_rvalid_i) w_state_nxt = r_cur.wb ? StRes : StIdle;
      StRes:   if (x_rready_i) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Current instruction, latency counter and result capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cur      <= '0;
      r_exe_cnt  <= '0;
      r_res_data <= '0;
    end else if (w_pop) begin
      r_cur     <= w_head;
      r_exe_cnt <= LatW'(EXE_LAT - 1);
    end else if (r_state == StExec) begin
      if (r_exe_cnt == '0) r_res_data <= w_alu;
      else                 r_exe_cnt  <= r_exe_cnt - LatW'(1);
    end else if ((r_state == StMwait) && xmem_rvalid_i && !r_cur.f3[2]) begin
      r_res_data <= xmem_status_i ? xmem_rdata_i : 32'd0;
    end
  end

  // Result and xmem outputs are driven only in their owning state, zero otherwise.
  always_comb begin
    x_rvalid_o              = 1'b0;
    x_rwaddr_o              = '0;
    x_rdata_o               = '0;
    xmem_valid_o            = 1'b0;
    xmem_req_type_o         = 1'b0;
    xmem_addr_o             = '0;
    xmem_wdata_o            = '0;
    xmem_endoftransaction_o = 1'b0;
    xmem_rready_o           = 1'b0;
    unique case (r_state)
      StRes: begin
        x_rvalid_o = 1'b1;
        x_rwaddr_o = r_cur.rd;
        x_rdata_o  = r_res_data;
      end
      StMreq: begin
        xmem_valid_o            = 1'b1;
        xmem_req_type_o         = r_cur.f3[2];
        xmem_addr_o             = r_cur.a;
        xmem_wdata_o            = r_cur.b;
        xmem_endoftransaction_o = 1'b1;
      end
      StMwait: xmem_rready_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cv32e40p_x_resp.sv
// Self-checking bench for cv32e40p_x_resp: expected results go into a scoreboard queue at
// offload time and are compared by a monitor when the result handshake completes.
`timescale 1ns/1ps
module tb_cv32e40p_x_resp;

  localparam logic [6:0] COMP = 7'b0001011;
  localparam logic [6:0] MEM  = 7'b0101011;
  localparam logic [6:0] BAD  = 7'b0110011;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             x_valid_i = 1'b0;
  logic             x_ready_o, x_accept_o, x_is_mem_op_o;
  logic [31:0]      x_instr_i = '0;
  logic [2:0][31:0] x_rs_i = '0;
  logic [2:0]       x_rs_valid_i = '0;
  logic             x_rd_clean_i = 1'b1;
  logic             x_rvalid_o;
  logic             x_rready_i = 1'b0;
  logic [4:0]       x_rwaddr_o;
  logic [31:0]      x_rdata_o;
  logic             xmem_valid_o;
  logic             xmem_ready_i = 1'b0;
  logic             xmem_req_type_o;
  logic [31:0]      xmem_addr_o, xmem_wdata_o;
  logic             xmem_endoftransaction_o;
  logic             xmem_rvalid_i = 1'b0;
  logic             xmem_rready_o;
  logic [31:0]      xmem_rdata_i = '0;
  logic             xmem_status_i = 1'b0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } res_t;

  res_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cv32e40p_x_resp dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .x_valid_i              (x_valid_i),
    .x_ready_o              (x_ready_o),
    .x_accept_o             (x_accept_o),
    .x_is_mem_op_o          (x_is_mem_op_o),
    .x_instr_i              (x_instr_i),
    .x_rs_i                 (x_rs_i),
    .x_rs_valid_i           (x_rs_valid_i),
    .x_rd_clean_i           (x_rd_clean_i),
    .x_rvalid_o             (x_rvalid_o),
    .x_rready_i             (x_rready_i),
    .x_rwaddr_o             (x_rwaddr_o),
    .x_rdata_o              (x_rdata_o),
    .xmem_valid_o           (xmem_valid_o),
    .xmem_ready_i           (xmem_ready_i),
    .xmem_req_type_o        (xmem_req_type_o),
    .xmem_addr_o            (xmem_addr_o),
    .xmem_wdata_o           (xmem_wdata_o),
    .xmem_endoftransaction_o(xmem_endoftransaction_o),
    .xmem_rvalid_i          (xmem_rvalid_i),
    .xmem_rready_o          (xmem_rready_o),
    .xmem_rdata_i           (xmem_rdata_i),
    .xmem_status_i          (xmem_status_i)
  );

  // Result monitor: every completed result handshake must match the scoreboard head.
  always @(negedge clk) begin
    res_t e;
    if (!rst && x_rvalid_o && x_rready_i) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_result: got rd=%0d data=%h, required no result",
                 x_rwaddr_o, x_rdata_o);
      end else begin
        e = sb.pop_front();
        if (x_rwaddr_o !== e.rd || x_rdata_o !== e.data) begin
          n_err++;
          $display("FAIL result_order: got rd=%0d data=%h, required rd=%0d data=%h",
                   x_rwaddr_o, x_rdata_o, e.rd, e.data);
        end
      end
    end
  end

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] rd,
                                     input logic [2:0] f3);
    return {17'd0, f3, rd, opc};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] rsv, input logic clean);
    x_valid_i    = 1'b1;
    x_instr_i    = instr;
    x_rs_i[0]    = a;
    x_rs_i[1]    = b;
    x_rs_valid_i = rsv;
    x_rd_clean_i = clean;
  endtask

  // Offer an instruction for up to budget cycles; hs reports whether the handshake completed.
  task automatic offer(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] rsv, input logic clean, input int budget,
                       output bit hs);
    drive(instr, a, b, rsv, clean);
    hs = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (x_ready_o) begin
        hs = 1'b1;
        break;
      end
      step();
    end
    if (hs) step();
    x_valid_i = 1'b0;
  endtask

  // Bounded wait for all outstanding results to be returned.
  task automatic drain(input string name, input int budget);
    int i;
    i = 0;
    while ((sb.size() != 0 || x_rvalid_o) && i < budget) begin
      step();
      i++;
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: got %0d results outstanding, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    drive(mk(COMP, 5'd1, 3'b000), 32'd1, 32'd2, 3'b011, 1'b1);
    @(negedge clk);
    n_vec += 4;
    if (x_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b, required 0", x_ready_o); end
    if (x_accept_o !== 1'b0) begin n_err++; $display("FAIL reset_accept: got %b, required 0", x_accept_o); end
    if ({x_rvalid_o, x_rwaddr_o, x_rdata_o} !== 38'd0) begin
      n_err++; $display("FAIL reset_result: got %b/%0d/%h, required 0", x_rvalid_o, x_rwaddr_o, x_rdata_o);
    end
    if ({xmem_valid_o, xmem_rready_o, xmem_addr_o, xmem_endoftransaction_o} !== 35'd0) begin
      n_err++; $display("FAIL reset_xmem: got valid=%b rready=%b addr=%h, required 0", xmem_valid_o, xmem_rready_o, xmem_addr_o);
    end
    step();
    x_valid_i = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_reject();
    bit seen;
    drive(mk(BAD, 5'd3, 3'b000), 32'd1, 32'd2, 3'b000, 1'b0);
    @(negedge clk);
    n_vec += 2;
    if (x_ready_o !== 1'b1) begin n_err++; $display("FAIL reject_ready: got %b, required 1", x_ready_o); end
    if (x_accept_o !== 1'b0 || x_is_mem_op_o !== 1'b0) begin
      n_err++; $display("FAIL reject_accept: got accept=%b mem=%b, required 0/0", x_accept_o, x_is_mem_op_o);
    end
    step();
    x_valid_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (x_rvalid_o || xmem_valid_o) seen = 1'b1;
      step();
    end
    n_vec++;
    if (seen) begin n_err++; $display("FAIL reject_enqueued: got activity=1, required 0"); end
  endtask

  task automatic test_compute_add();
    x_rready_i = 1'b0;
    drive(mk(COMP, 5'd3, 3'b000), 32'd5, 32'd7, 3'b011, 1'b1);
    @(negedge clk);
    n_vec++;
    if ({x_ready_o, x_accept_o, x_is_mem_op_o} !== 3'b110) begin
      n_err++; $display("FAIL add_handshake: got rdy/acc/mem=%b, required 110", {x_ready_o, x_accept_o, x_is_mem_op_o});
    end
    sb.push_back('{rd: 5'd3, data: 32'd12});
    step();
    x_valid_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_vec++;
      if (x_rvalid_o !== (k == 5)) begin
        n_err++; $display("FAIL add_latency_c%0d: got rvalid=%b, required %b", k, x_rvalid_o, k == 5);
      end
      if (k < 5) step();
    end
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if ({x_rvalid_o, x_rwaddr_o, x_rdata_o} !== {1'b1, 5'd3, 32'd12}) begin
        n_err++; $display("FAIL add_hold_%0d: got %b/%0d/%h, required 1/3/0000000c", k, x_rvalid_o, x_rwaddr_o, x_rdata_o);
      end
      step();
      if (k < 2) @(negedge clk);
    end
    x_rready_i = 1'b1;
    drain("add", 10);
  endtask

  task automatic test_compute_ops();
    logic [2:0]  f3_t [7] = '{3'b001, 3'b010, 3'b011, 3'b000, 3'b101, 3'b000, 3'b000};
    logic [4:0]  rd_t [7] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd0, 5'd7};
    logic [31:0] a_t  [7] = '{32'd0, 32'hF0F0_F0F0, 32'd1, 32'hFFFF_FFFF, 32'h1234, 32'd7, 32'd7};
    logic [31:0] b_t  [7] = '{32'd1, 32'h0FF0_0FF0, 32'h23, 32'd2, 32'd99, 32'd7, 32'd8};
    logic [31:0] e_t  [7] = '{32'hFFFF_FFFF, 32'hFF00_FF00, 32'd8, 32'd1, 32'h1234, 32'd0, 32'd15};
    bit hs;
    x_rready_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      // rd=0 writes nothing back, so a dirty rd must not stall it.
      offer(mk(COMP, rd_t[i], f3_t[i]), a_t[i], b_t[i], 3'b011, rd_t[i] != 5'd0, 20, hs);
      n_vec++;
      if (!hs) begin n_err++; $display("FAIL ops_hs_%0d: got handshake=0, required 1", i); end
      else if (rd_t[i] != 5'd0) sb.push_back('{rd: rd_t[i], data: e_t[i]});
    end
    drain("ops", 60);
  endtask

  task automatic test_load();
    bit found;
    x_rready_i   = 1'b1;
    xmem_ready_i = 1'b0;
    drive(mk(MEM, 5'd4, 3'b010), 32'h100, 32'hAAAA, 3'b001, 1'b1);
    @(negedge clk);
    n_vec++;
    if ({x_ready_o, x_accept_o, x_is_mem_op_o} !== 3'b111) begin
      n_err++; $display("FAIL load_handshake: got rdy/acc/mem=%b, required 111", {x_ready_o, x_accept_o, x_is_mem_op_o});
    end
    sb.push_back('{rd: 5'd4, data: 32'hDEAD});
    step();
    x_valid_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge clk);
      if (xmem_valid_o) found = 1'b1;
      else step();
    end
    n_vec++;
    if (!found) begin n_err++; $display("FAIL load_req_timeout: got no xmem_valid, required request"); end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if ({xmem_valid_o, xmem_req_type_o, xmem_endoftransaction_o, xmem_addr_o} !== {3'b101, 32'h100}) begin
        n_err++; $display("FAIL load_req_%0d: got v/t/eot=%b addr=%h, required 101 addr=00000100", k, {xmem_valid_o, xmem_req_type_o, xmem_endoftransaction_o}, xmem_addr_o);
      end
      step();
      if (k == 2) xmem_ready_i = 1'b1;
      if (k < 3) @(negedge clk);
    end
    xmem_ready_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({xmem_rready_o, xmem_valid_o} !== 2'b10) begin
      n_err++; $display("FAIL load_wait: got rready/valid=%b, required 10", {xmem_rready_o, xmem_valid_o});
    end
    step();
    xmem_rvalid_i = 1'b1; xmem_rdata_i = 32'hDEAD; xmem_status_i = 1'b1;
    step();
    xmem_rvalid_i = 1'b0;
    drain("load", 10);
    // A failed load returns zero regardless of the bus data.
    offer(mk(MEM, 5'd5, 3'b000), 32'h104, 32'd0, 3'b001, 1'b1, 4, found);
    sb.push_back('{rd: 5'd5, data: 32'd0});
    xmem_ready_i = 1'b1;
    for (int i = 0; i < 8 && !xmem_rready_o; i++) step();
    xmem_ready_i = 1'b0;
    xmem_rvalid_i = 1'b1; xmem_rdata_i = 32'hBEEF; xmem_status_i = 1'b0;
    step();
    xmem_rvalid_i = 1'b0;
    drain("load_err", 10);
  endtask

  task automatic test_store();
    bit found, seen;
    x_rready_i   = 1'b1;
    xmem_ready_i = 1'b1;
    // Stores never write back, so a dirty rd must not block them.
    drive(mk(MEM, 5'd9, 3'b110), 32'h200, 32'h55, 3'b011, 1'b0);
    @(negedge clk);
    n_vec++;
    if ({x_ready_o, x_accept_o, x_is_mem_op_o} !== 3'b111) begin
      n_err++; $display("FAIL store_handshake: got rdy/acc/mem=%b, required 111", {x_ready_o, x_accept_o, x_is_mem_op_o});
    end
    step();
    x_valid_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge clk);
      if (xmem_valid_o) found = 1'b1;
      else step();
    end
    n_vec++;
    if (!found || {xmem_req_type_o, xmem_endoftransaction_o, xmem_addr_o, xmem_wdata_o} !== {2'b11, 32'h200, 32'h55}) begin
      n_err++; $display("FAIL store_req: got found=%b t/eot=%b addr=%h wdata=%h, required 1 11 00000200 00000055", found, {xmem_req_type_o, xmem_endoftransaction_o}, xmem_addr_o, xmem_wdata_o);
    end
    step();
    xmem_ready_i = 1'b0;
    xmem_rvalid_i = 1'b1; xmem_rdata_i = 32'hFFFF; xmem_status_i = 1'b1;
    step();
    xmem_rvalid_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (x_rvalid_o) seen = 1'b1;
      step();
    end
    n_vec++;
    if (seen) begin n_err++; $display("FAIL store_result: got rvalid=1, required never"); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f3_t [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b000};
    logic [31:0] a_t  [5] = '{32'd10, 32'd20, 32'hFF, 32'd3, 32'd100};
    logic [31:0] b_t  [5] = '{32'd1, 32'd3, 32'h0F, 32'd4, 32'd200};
    logic [31:0] e_t  [5] = '{32'd11, 32'd17, 32'hF0, 32'd48, 32'd300};
    bit hs;
    x_rready_i = 1'b0;
    // One instruction in flight plus DEPTH queued are accepted back to back.
    for (int i = 0; i < 5; i++) begin
      offer(mk(COMP, 5'(i + 1), f3_t[i]), a_t[i], b_t[i], 3'b011, 1'b1, 1, hs);
      n_vec++;
      if (!hs) begin n_err++; $display("FAIL b2b_hs_%0d: got handshake=0, required 1", i); end
      else sb.push_back('{rd: 5'(i + 1), data: e_t[i]});
    end
    offer(mk(COMP, 5'd6, 3'b000), 32'd1, 32'd1, 3'b011, 1'b1, 4, hs);
    n_vec++;
    if (hs) begin n_err++; $display("FAIL b2b_full_stall: got handshake=1, required 0"); end
    drive(mk(BAD, 5'd1, 3'b000), 32'd0, 32'd0, 3'b000, 1'b1);
    @(negedge clk);
    n_vec++;
    if ({x_ready_o, x_accept_o} !== 2'b10) begin
      n_err++; $display("FAIL b2b_reject_full: got rdy/acc=%b, required 10", {x_ready_o, x_accept_o});
    end
    step();
    drive(mk(COMP, 5'd6, 3'b000), 32'd1, 32'd1, 3'b011, 1'b1);
    x_rready_i = 1'b1;
    // Result handshake cycle, then the pop cycle from a full queue, then space frees up.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_vec++;
      if (x_ready_o !== (k == 2)) begin
        n_err++; $display("FAIL b2b_release_c%0d: got ready=%b, required %b", k, x_ready_o, k == 2);
      end
      step();
    end
    sb.push_back('{rd: 5'd6, data: 32'd2});
    x_valid_i = 1'b0;
    drain("b2b", 80);
  endtask

  task automatic test_gating_reset();
    bit hs, seen;
    x_rready_i = 1'b0;
    drive(mk(COMP, 5'd2, 3'b000), 32'd1, 32'd2, 3'b001, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_vec++;
      if (x_ready_o !== 1'b0) begin n_err++; $display("FAIL gate_rs1_%0d: got ready=%b, required 0", k, x_ready_o); end
      step();
    end
    drive(mk(COMP, 5'd2, 3'b000), 32'd1, 32'd2, 3'b011, 1'b0);
    @(negedge clk);
    n_vec++;
    if (x_ready_o !== 1'b0) begin n_err++; $display("FAIL gate_rd_clean: got ready=%b, required 0", x_ready_o); end
    step();
    x_rd_clean_i = 1'b1;
    @(negedge clk);
    n_vec++;
    if (x_ready_o !== 1'b1) begin n_err++; $display("FAIL gate_release: got ready=%b, required 1", x_ready_o); end
    step();
    x_valid_i = 1'b0;
    offer(mk(COMP, 5'd3, 3'b000), 32'd3, 32'd3, 3'b011, 1'b1, 2, hs);
    offer(mk(COMP, 5'd4, 3'b000), 32'd4, 32'd4, 3'b011, 1'b1, 2, hs);
    repeat (4) step();
    drive(mk(COMP, 5'd5, 3'b000), 32'd5, 32'd5, 3'b011, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    n_vec += 2;
    if ({x_ready_o, x_accept_o, x_rvalid_o, x_rwaddr_o, x_rdata_o} !== 40'd0) begin
      n_err++; $display("FAIL midreset_x: got rdy=%b rvalid=%b rd=%0d data=%h, required 0", x_ready_o, x_rvalid_o, x_rwaddr_o, x_rdata_o);
    end
    if ({xmem_valid_o, xmem_rready_o} !== 2'b00) begin
      n_err++; $display("FAIL midreset_xmem: got valid/rready=%b, required 00", {xmem_valid_o, xmem_rready_o});
    end
    step();
    x_valid_i = 1'b0;
    rst = 1'b0;
    sb.delete();
    x_rready_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (x_rvalid_o || xmem_valid_o) seen = 1'b1;
      step();
    end
    n_vec++;
    if (seen) begin n_err++; $display("FAIL midreset_flush: got stale activity=1, required 0"); end
    offer(mk(COMP, 5'd1, 3'b000), 32'd40, 32'd2, 3'b011, 1'b1, 2, hs);
    n_vec++;
    if (!hs) begin n_err++; $display("FAIL post_reset_hs: got handshake=0, required 1"); end
    else sb.push_back('{rd: 5'd1, data: 32'd42});
    drain("post_reset", 12);
  endtask

  initial begin
    test_reset();
    test_reject();
    test_compute_add();
    test_compute_ops();
    test_load();
    test_store();
    test_back_to_back();
    test_gating_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
